// File: rtl/credit_link_tx_pkg.sv
// Shared definitions for the credit-based link transmitter.
//   DEF_CHANNEL_WIDTH  : flit width; the top bit is the flit-present bit
//   DEF_BUFFER_DEPTH   : downstream input-buffer slots (initial credit count)
//   DEF_FIFO_DEPTH     : local staging FIFO entries (power of 2, >= 2)
//   credit_op_e        : per-edge credit counter action
package credit_link_tx_pkg;

    localparam int DEF_CHANNEL_WIDTH = 16;
    localparam int FLIT_PRESENT_BIT  = DEF_CHANNEL_WIDTH - 1;
    localparam int DEF_BUFFER_DEPTH  = 5;
    localparam int DEF_FIFO_DEPTH    = 4;
    localparam int DEF_CNT_WIDTH     = $clog2(DEF_BUFFER_DEPTH + 1);

    typedef enum logic [1:0] {
        CRED_HOLD = 2'd0,
        CRED_DEC  = 2'd1,
        CRED_INC  = 2'd2,
        CRED_SAT  = 2'd3
    } credit_op_e;

endpackage

// File: rtl/credit_link_tx_if.sv
// Link interface between local logic / downstream node and the transmitter.
//   flit_din, flit_valid_din, flit_ready_dout : local push handshake
//   channel_dout                              : registered flit to downstream
//   credit_in_din                             : returned-credit pulse
//   credits_dout, credit_overflow_dout        : credit status
// master = producer and downstream side, slave = the transmitter.
interface credit_link_tx_if
    import credit_link_tx_pkg::*;
#(
    parameter int CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
);
    logic [CHANNEL_WIDTH-1:0] flit_din;
    logic                     flit_valid_din;
    logic                     flit_ready_dout;
    logic [CHANNEL_WIDTH-1:0] channel_dout;
    logic                     credit_in_din;
    logic [CNT_WIDTH-1:0]     credits_dout;
    logic                     credit_overflow_dout;

    modport master (
        output flit_din, flit_valid_din, credit_in_din,
        input  flit_ready_dout, channel_dout, credits_dout, credit_overflow_dout
    );

    modport slave (
        input  flit_din, flit_valid_din, credit_in_din,
        output flit_ready_dout, channel_dout, credits_dout, credit_overflow_dout
    );
endinterface

// File: rtl/credit_link_tx_sync_fifo.sv
// Synchronous staging FIFO with combinational head read.
//   clk, reset (active-low, synchronous)
//   push/din  : write an entry (ignored when full)
//   pop       : drop the head entry (ignored when empty)
//   dout      : current head entry
//   full, empty, count : occupancy status
module sync_fifo
    import credit_link_tx_pkg::*;
#(
    parameter int WIDTH = DEF_CHANNEL_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/credit_link_tx.sv
// Transmit end of the credit-based inter-node channel.
//   clk   : system clock
//   reset : synchronous, active-low
//   link  : credit_link_tx_if slave port carrying the push handshake, the
//           registered channel output, the credit return pulse and the
//           credit count / sticky overflow status.
// Flits are staged in a small FIFO and released one per cycle while credits
// remain; each sent flit occupies channel_dout for exactly one cycle.
module credit_link_tx
    import credit_link_tx_pkg::*;
#(
    parameter int CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
    parameter int BUFFER_DEPTH  = DEF_BUFFER_DEPTH,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int CNT_WIDTH     = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    credit_link_tx_if.slave  link
);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_WIDTH-1:0] CRED_MAX   = CNT_WIDTH'(BUFFER_DEPTH);
    localparam logic [FCNT_W-1:0]    FIFO_LIMIT = FCNT_W'(FIFO_DEPTH);

    logic [CHANNEL_WIDTH-1:0] head_p0;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [FCNT_W-1:0]        fifo_count;
    logic                     ready_p0;
    logic                     push_p0;
    logic                     send_p0;
    logic [CNT_WIDTH-1:0]     credits;
    logic                     overflow;
    logic [CHANNEL_WIDTH-1:0] chan_p1;

    // Credit counter action for one edge. A credit arriving at the maximum
    // count saturates unless a send consumes a slot on the same edge.
    function automatic credit_op_e credit_op(input logic send,
                                             input logic credit_in,
                                             input logic at_max);
        credit_op_e op;
        op = CRED_HOLD;
        if (send && !credit_in) begin
            op = CRED_DEC;
        end else if (!send && credit_in) begin
            op = at_max ? CRED_SAT : CRED_INC;
        end
        return op;
    endfunction

    // Stage p0: accept handshake and send decision from registered state.
    assign ready_p0 = reset && (fifo_count < FIFO_LIMIT);
    assign push_p0  = link.flit_valid_din && ready_p0 && !fifo_full;
    assign send_p0  = !fifo_empty && (credits != '0);

    sync_fifo #(
        .WIDTH (CHANNEL_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_p0),
        .pop   (send_p0),
        .din   (link.flit_din),
        .dout  (head_p0),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Stage p1: channel register and credit state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            chan_p1  <= '0;
            credits  <= CRED_MAX;
            overflow <= 1'b0;
        end else begin
            chan_p1 <= send_p0 ? head_p0 : '0;
            case (credit_op(send_p0, link.credit_in_din, credits == CRED_MAX))
                CRED_DEC: credits  <= credits - 1'b1;
                CRED_INC: credits  <= credits + 1'b1;
                CRED_SAT: overflow <= 1'b1;
                default:  credits  <= credits;
            endcase
        end
    end

    assign link.flit_ready_dout      = ready_p0;
    assign link.channel_dout         = chan_p1;
    assign link.credits_dout         = credits;
    assign link.credit_overflow_dout = overflow;
endmodule

// File: tb/tb_credit_link_tx.sv
module tb_credit_link_tx;
    logic clk = 1'b0;
    logic reset = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    credit_link_tx_if #(.CHANNEL_WIDTH(16), .CNT_WIDTH(3)) lk ();

    credit_link_tx #(
        .CHANNEL_WIDTH (16),
        .BUFFER_DEPTH  (5),
        .FIFO_DEPTH    (4),
        .CNT_WIDTH     (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .link  (lk)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every non-idle channel cycle must match the next
    // expected flit in arrival order.
    always @(negedge clk) begin
        if (lk.channel_dout !== 16'h0) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_flit: got %0h expected none", lk.channel_dout);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (lk.channel_dout !== e) begin
                    miscompares++;
                    $display("FAIL flit_order: got %0h expected %0h", lk.channel_dout, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        lk.flit_din       = '0;
        lk.flit_valid_din = 1'b0;
        lk.credit_in_din  = 1'b0;

        // 1: reset then idle
        reset = 1'b0;
        tick();
        tick();
        chk("ready_in_reset", lk.flit_ready_dout, 0);
        reset = 1'b1;
        repeat (10) tick();
        chk("t1_credits", lk.credits_dout, 5);
        chk("t1_chan", lk.channel_dout, 0);
        chk("t1_ready", lk.flit_ready_dout, 1);
        chk("t1_ovf", lk.credit_overflow_dout, 0);

        // 2: A..E back to back, credits run out, F stays queued
        for (int i = 0; i < 5; i++) begin
            lk.flit_din = 16'h8200 + 16'(i);
            lk.flit_valid_din = 1'b1;
            exp_q.push_back(16'h8200 + 16'(i));
            tick();
            chk("t2_credits", lk.credits_dout, 5 - i);
            chk("t2_chan", lk.channel_dout, (i == 0) ? 32'h0 : 32'h8200 + i - 1);
        end
        lk.flit_din = 16'h8206;
        exp_q.push_back(16'h8206);
        tick();
        lk.flit_valid_din = 1'b0;
        chk("t2_credits_zero", lk.credits_dout, 0);
        chk("t2_chan_E", lk.channel_dout, 16'h8204);
        tick();
        chk("t2_F_held", lk.channel_dout, 0);
        tick();
        chk("t2_F_held2", lk.channel_dout, 0);
        lk.credit_in_din = 1'b1;
        tick();
        lk.credit_in_din = 1'b0;
        chk("t2_credit_back", lk.credits_dout, 1);
        chk("t2_chan_idle", lk.channel_dout, 0);
        tick();
        chk("t2_F_sent", lk.channel_dout, 16'h8206);
        chk("t2_credits_again", lk.credits_dout, 0);

        // 3: fill FIFO at zero credits, then release two
        for (int i = 0; i < 4; i++) begin
            lk.flit_din = 16'h8300 + 16'(i);
            lk.flit_valid_din = 1'b1;
            exp_q.push_back(16'h8300 + 16'(i));
            tick();
            chk("t3_ready", lk.flit_ready_dout, (i < 3) ? 1 : 0);
        end
        lk.flit_din = 16'h830F;
        tick();
        tick();
        chk("t3_held_off", lk.flit_ready_dout, 0);
        chk("t3_chan_idle", lk.channel_dout, 0);
        lk.flit_valid_din = 1'b0;
        lk.credit_in_din = 1'b1;
        tick();
        chk("t3_cred1", lk.credits_dout, 1);
        chk("t3_chan0", lk.channel_dout, 0);
        tick();
        lk.credit_in_din = 1'b0;
        chk("t3_G", lk.channel_dout, 16'h8300);
        chk("t3_cred_hold", lk.credits_dout, 1);
        tick();
        chk("t3_H", lk.channel_dout, 16'h8301);
        chk("t3_cred0", lk.credits_dout, 0);
        chk("t3_ready_back", lk.flit_ready_dout, 1);
        tick();
        chk("t3_only_two", lk.channel_dout, 0);

        // 4: streaming with a credit every cycle
        lk.credit_in_din = 1'b1;
        tick();
        chk("t4_cred_start", lk.credits_dout, 1);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                lk.flit_din = 16'h8400 + 16'(i);
                lk.flit_valid_din = 1'b1;
                exp_q.push_back(16'h8400 + 16'(i));
            end else begin
                lk.flit_valid_din = 1'b0;
            end
            tick();
            chk("t4_cred_const", lk.credits_dout, 1);
            chk("t4_stream", lk.channel_dout,
                (i == 0) ? 32'h8302 : (i == 1) ? 32'h8303 : 32'h8400 + i - 2);
        end
        lk.credit_in_din = 1'b0;
        chk("t4_ovf", lk.credit_overflow_dout, 0);
        lk.credit_in_din = 1'b1;
        repeat (4) tick();
        lk.credit_in_din = 1'b0;
        chk("t4_cred_full", lk.credits_dout, 5);
        // credit at max together with a send is legal
        lk.flit_din = 16'h8500;
        lk.flit_valid_din = 1'b1;
        exp_q.push_back(16'h8500);
        tick();
        lk.flit_valid_din = 1'b0;
        lk.credit_in_din = 1'b1;
        tick();
        lk.credit_in_din = 1'b0;
        chk("t4_max_send_cred", lk.credits_dout, 5);
        chk("t4_max_send_ovf", lk.credit_overflow_dout, 0);

        // 5: overflow at full credits
        lk.credit_in_din = 1'b1;
        tick();
        lk.credit_in_din = 1'b0;
        chk("t5_cred_sat", lk.credits_dout, 5);
        chk("t5_ovf_set", lk.credit_overflow_dout, 1);
        repeat (3) tick();
        chk("t5_ovf_sticky", lk.credit_overflow_dout, 1);

        // 6: reset with flits queued
        for (int i = 0; i < 8; i++) begin
            lk.flit_din = (i < 5) ? 16'h8600 + 16'(i) : 16'h8700 + 16'(i);
            lk.flit_valid_din = 1'b1;
            if (i < 5) exp_q.push_back(16'h8600 + 16'(i));
            tick();
        end
        lk.flit_valid_din = 1'b0;
        chk("t6_cred0", lk.credits_dout, 0);
        chk("t6_ready_pre", lk.flit_ready_dout, 1);
        reset = 1'b0;
        tick();
        chk("t6_rst_cred", lk.credits_dout, 5);
        chk("t6_rst_chan", lk.channel_dout, 0);
        chk("t6_rst_ready", lk.flit_ready_dout, 0);
        chk("t6_rst_ovf", lk.credit_overflow_dout, 0);
        reset = 1'b1;
        tick();
        chk("t6_ready_post", lk.flit_ready_dout, 1);
        repeat (5) begin
            tick();
            chk("t6_no_stale", lk.channel_dout, 0);
        end
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
